// File: rtl/risc_prog_loader_if.sv
// Stream-in and memory-write bus between the program loader and its neighbours.
// The stream source drives in_valid/in_data, and the loader drives in_ready plus the registered memory write port.
interface risc_prog_loader_if #(
    parameter int unsigned AWIDTH = 5,
    parameter int unsigned DWIDTH = 8
);
    logic              in_valid;
    logic [DWIDTH-1:0] in_data;
    logic              in_ready;
    logic              mem_wr;
    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_wr, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/risc_prog_loader.sv
// Loads a byte-stream program image into the core memory while holding the core in reset.
// It then releases the core and counts run clocks until halt or timeout.
module risc_prog_loader #(
    parameter int unsigned AWIDTH     = 5,
    parameter int unsigned DWIDTH     = 8,
    parameter int unsigned CWIDTH     = 16,
    parameter int unsigned RST_CYCLES = 2,
    parameter int unsigned MAX_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    risc_prog_loader_if.slave bus,
    input  logic              cpu_halt,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [CWIDTH-1:0] cycles
);
    localparam int unsigned DEPTH  = 1 << AWIDTH;
    localparam int unsigned RWIDTH = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CRST,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state;
    logic [AWIDTH:0]   addr_cnt;
    logic [RWIDTH-1:0] rst_cnt;

    // Single registered FSM; every output is a flop updated here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            addr_cnt      <= '0;
            rst_cnt       <= '0;
            cpu_rst       <= 1'b1;
            bus.in_ready  <= 1'b0;
            bus.mem_wr    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            timeout       <= 1'b0;
            cycles        <= '0;
        end else begin
            bus.mem_wr <= 1'b0;
            case (state)
                S_IDLE: begin
                    cpu_rst <= 1'b1;
                    if (start) begin
                        state        <= S_LOAD;
                        addr_cnt     <= '0;
                        bus.in_ready <= 1'b1;
                        busy         <= 1'b1;
                    end
                end

                S_LOAD: begin
                    cpu_rst <= 1'b1;
                    if (bus.in_valid && bus.in_ready) begin
                        bus.mem_wr    <= 1'b1;
                        bus.mem_addr  <= addr_cnt[AWIDTH-1:0];
                        bus.mem_wdata <= DWIDTH'(bus.in_data);
                        addr_cnt      <= addr_cnt + 1'b1;
                        // Terminal compare on the full-width count so the image never wraps.
                        if (addr_cnt == (AWIDTH+1)'(DEPTH - 1)) begin
                            bus.in_ready <= 1'b0;
                            rst_cnt      <= '0;
                            state        <= S_CRST;
                        end
                    end
                end

                S_CRST: begin
                    if (rst_cnt == RWIDTH'(RST_CYCLES - 1)) begin
                        cpu_rst <= 1'b0;
                        cycles  <= '0;
                        state   <= S_RUN;
                    end else begin
                        cpu_rst <= 1'b1;
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end

                S_RUN: begin
                    cpu_rst <= 1'b0;
                    // Halt takes priority over reaching the cycle limit.
                    if (cpu_halt) begin
                        state   <= S_DONE;
                        done    <= 1'b1;
                        timeout <= 1'b0;
                        busy    <= 1'b0;
                    end else if (cycles == CWIDTH'(MAX_CYCLES - 1)) begin
                        cycles  <= CWIDTH'(MAX_CYCLES);
                        state   <= S_DONE;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        cycles <= cycles + 1'b1;
                    end
                end

                S_DONE: begin
                    cpu_rst <= 1'b0;
                    if (start) begin
                        state        <= S_LOAD;
                        addr_cnt     <= '0;
                        bus.in_ready <= 1'b1;
                        busy         <= 1'b1;
                        cpu_rst      <= 1'b1;
                        done         <= 1'b0;
                        timeout      <= 1'b0;
                        cycles       <= '0;
                    end
                end

                default: begin
                    state   <= S_IDLE;
                    cpu_rst <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_risc_prog_loader.sv
// Directed bench for risc_prog_loader: reset, load paths, run/halt/timeout and restart behaviour.
module tb_risc_prog_loader;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        cpu_halt;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [15:0] cycles;

    int n_checks = 0;
    int n_fail   = 0;

    risc_prog_loader_if #(.AWIDTH(5), .DWIDTH(8)) bus ();

    risc_prog_loader #(.MAX_CYCLES(20)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus),
        .cpu_halt (cpu_halt),
        .cpu_rst  (cpu_rst),
        .busy     (busy),
        .done     (done),
        .timeout  (timeout),
        .cycles   (cycles)
    );

    always #5 clk = ~clk;

    // Memory model and write log, sampled mid-cycle.
    logic [7:0] mem [32];
    logic [4:0] log_addr [$];
    logic [7:0] log_data [$];
    int         log_cyc  [$];
    int         cyc = 0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.mem_wr === 1'b1) begin
            log_addr.push_back(bus.mem_addr);
            log_data.push_back(bus.mem_wdata);
            log_cyc.push_back(cyc);
            mem[bus.mem_addr] = bus.mem_wdata;
        end
    end

    task automatic clear_log;
        log_addr.delete();
        log_data.delete();
        log_cyc.delete();
    endtask

    task automatic send_bytes(input bit do_start, input bit throttle, input logic [7:0] base, input int nbytes);
        int k = 0;
        int guard = 0;
        bit phase = 1'b0;
        if (do_start) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        while (k < nbytes && guard < 400) begin
            if (throttle && phase) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'hEE;
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = base + 8'(k);
            end
            if (bus.in_valid && bus.in_ready === 1'b1) k++;
            phase = ~phase;
            guard++;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        n_checks++;
        if (k != nbytes) begin n_fail++; $display("FAIL send_bytes: accepted %0d bytes, required %0d", k, nbytes); end
    endtask

    task automatic wait_run;
        int g = 0;
        while (!(cpu_rst === 1'b0 && busy === 1'b1) && g < 100) begin @(negedge clk); g++; end
        n_checks++;
        if (g >= 100) begin n_fail++; $display("FAIL wait_run: cpu_rst=%b busy=%b, required 0/1", cpu_rst, busy); end
    endtask

    task automatic wait_cycles(input logic [15:0] val);
        int g = 0;
        while (cycles !== val && g < 100) begin @(negedge clk); g++; end
        n_checks++;
        if (g >= 100) begin n_fail++; $display("FAIL wait_cycles: cycles=%0d, required %0d", cycles, val); end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (cpu_rst !== 1'b1) begin n_fail++; $display("FAIL rst_cpu_rst: got %b req 1", cpu_rst); end
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b req 0", bus.in_ready); end
        n_checks++; if (bus.mem_wr !== 1'b0) begin n_fail++; $display("FAIL rst_mem_wr: got %b req 0", bus.mem_wr); end
        n_checks++; if (bus.mem_addr !== 5'd0 || bus.mem_wdata !== 8'h00) begin n_fail++; $display("FAIL rst_mem_bus: addr %h data %h req 0/0", bus.mem_addr, bus.mem_wdata); end
        n_checks++; if (busy !== 1'b0 || done !== 1'b0 || timeout !== 1'b0) begin n_fail++; $display("FAIL rst_flags: busy %b done %b timeout %b req 000", busy, done, timeout); end
        n_checks++; if (cycles !== 16'd0) begin n_fail++; $display("FAIL rst_cycles: got %0d req 0", cycles); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (cpu_rst !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_hold: cpu_rst %b busy %b req 1/0", cpu_rst, busy); end
    endtask

    task automatic test_abort_load;
        clear_log();
        send_bytes(1'b1, 1'b0, 8'hC0, 10);
        n_checks++; if (bus.mem_wr !== 1'b1 || bus.mem_addr !== 5'd9) begin n_fail++; $display("FAIL abort_pre: mem_wr %b addr %0d req 1/9", bus.mem_wr, bus.mem_addr); end
        // Assert reset mid-cycle, away from any clock edge.
        #2 rst = 1'b1;
        #1;
        n_checks++; if (cpu_rst !== 1'b1) begin n_fail++; $display("FAIL abort_cpu_rst: got %b req 1", cpu_rst); end
        n_checks++; if (bus.mem_wr !== 1'b0) begin n_fail++; $display("FAIL abort_mem_wr: got %b req 0", bus.mem_wr); end
        n_checks++; if (bus.in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL abort_flags: in_ready %b busy %b done %b req 000", bus.in_ready, busy, done); end
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (log_addr.size() != 10) begin n_fail++; $display("FAIL abort_writes: got %0d req 10", log_addr.size()); end
        n_checks++; if (mem[9] !== 8'hC9 || mem[10] !== 8'h00) begin n_fail++; $display("FAIL abort_partial: mem9 %h mem10 %h req C9/00", mem[9], mem[10]); end
    endtask

    task automatic test_back_to_back;
        clear_log();
        send_bytes(1'b1, 1'b0, 8'h00, 32);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h20;
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_drop: got %b req 0", bus.in_ready); end
        n_checks++; if (bus.mem_wr !== 1'b1 || bus.mem_addr !== 5'd31 || bus.mem_wdata !== 8'h1F) begin n_fail++; $display("FAIL b2b_last_write: wr %b addr %0d data %h req 1/31/1F", bus.mem_wr, bus.mem_addr, bus.mem_wdata); end
        n_checks++; if (cpu_rst !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_crst1: cpu_rst %b busy %b req 1/1", cpu_rst, busy); end
        @(negedge clk);
        n_checks++; if (cpu_rst !== 1'b1 || bus.mem_wr !== 1'b0) begin n_fail++; $display("FAIL b2b_crst2: cpu_rst %b mem_wr %b req 1/0", cpu_rst, bus.mem_wr); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        n_checks++; if (cpu_rst !== 1'b0 || busy !== 1'b1 || cycles !== 16'd0) begin n_fail++; $display("FAIL b2b_run_entry: cpu_rst %b busy %b cycles %0d req 0/1/0", cpu_rst, busy, cycles); end
        n_checks++; if (log_addr.size() != 32) begin n_fail++; $display("FAIL b2b_count: got %0d writes req 32", log_addr.size()); end
        for (int k = 0; k < log_addr.size(); k++) begin
            n_checks++;
            if (log_addr[k] !== 5'(k) || log_data[k] !== 8'(k) || log_cyc[k] != log_cyc[0] + k) begin
                n_fail++;
                $display("FAIL b2b_write_%0d: addr %0d data %h cyc_off %0d req %0d/%h/%0d", k, log_addr[k], log_data[k], log_cyc[k] - log_cyc[0], k, 8'(k), k);
            end
        end
    endtask

    task automatic test_start_ignored_in_run;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++; if (busy !== 1'b1 || bus.in_ready !== 1'b0 || cpu_rst !== 1'b0) begin n_fail++; $display("FAIL run_start_ignored: busy %b in_ready %b cpu_rst %b req 1/0/0", busy, bus.in_ready, cpu_rst); end
        n_checks++; if (cycles !== 16'd1 || done !== 1'b0) begin n_fail++; $display("FAIL run_count: cycles %0d done %b req 1/0", cycles, done); end
    endtask

    task automatic test_halt_count;
        wait_cycles(16'd4);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL halt_pre: done %b req 0", done); end
        cpu_halt = 1'b1;
        @(negedge clk);
        cpu_halt = 1'b0;
        n_checks++; if (done !== 1'b1 || timeout !== 1'b0 || cycles !== 16'd4) begin n_fail++; $display("FAIL halt_done: done %b timeout %b cycles %0d req 1/0/4", done, timeout, cycles); end
        n_checks++; if (busy !== 1'b0 || cpu_rst !== 1'b0) begin n_fail++; $display("FAIL halt_outputs: busy %b cpu_rst %b req 0/0", busy, cpu_rst); end
        @(negedge clk);
        n_checks++; if (done !== 1'b1 || cycles !== 16'd4) begin n_fail++; $display("FAIL halt_sticky: done %b cycles %0d req 1/4", done, cycles); end
    endtask

    task automatic test_rerun_from_done;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++; if (done !== 1'b0 || timeout !== 1'b0 || cycles !== 16'd0) begin n_fail++; $display("FAIL rerun_clear: done %b timeout %b cycles %0d req 0/0/0", done, timeout, cycles); end
        n_checks++; if (busy !== 1'b1 || bus.in_ready !== 1'b1 || cpu_rst !== 1'b1) begin n_fail++; $display("FAIL rerun_load: busy %b in_ready %b cpu_rst %b req 1/1/1", busy, bus.in_ready, cpu_rst); end
    endtask

    task automatic test_throttled_load;
        clear_log();
        send_bytes(1'b0, 1'b1, 8'h40, 32);
        repeat (2) @(negedge clk);
        n_checks++; if (log_addr.size() != 32) begin n_fail++; $display("FAIL thr_count: got %0d writes req 32", log_addr.size()); end
        for (int k = 0; k < log_addr.size(); k++) begin
            n_checks++;
            if (log_addr[k] !== 5'(k) || log_data[k] !== 8'h40 + 8'(k) || (k > 0 && log_cyc[k] != log_cyc[k-1] + 2)) begin
                n_fail++;
                $display("FAIL thr_write_%0d: addr %0d data %h req %0d/%h", k, log_addr[k], log_data[k], k, 8'h40 + 8'(k));
            end
        end
    endtask

    task automatic test_timeout;
        wait_run();
        wait_cycles(16'd19);
        n_checks++; if (done !== 1'b0 || timeout !== 1'b0) begin n_fail++; $display("FAIL to_pre: done %b timeout %b req 0/0", done, timeout); end
        @(negedge clk);
        n_checks++; if (done !== 1'b1 || timeout !== 1'b1 || cycles !== 16'd20 || busy !== 1'b0) begin n_fail++; $display("FAIL to_hit: done %b timeout %b cycles %0d busy %b req 1/1/20/0", done, timeout, cycles, busy); end
        repeat (5) @(negedge clk);
        n_checks++; if (cycles !== 16'd20 || done !== 1'b1 || timeout !== 1'b1) begin n_fail++; $display("FAIL to_hold: cycles %0d done %b timeout %b req 20/1/1", cycles, done, timeout); end
    endtask

    task automatic test_halt_at_limit;
        send_bytes(1'b1, 1'b0, 8'h80, 32);
        wait_run();
        wait_cycles(16'd19);
        cpu_halt = 1'b1;
        @(negedge clk);
        cpu_halt = 1'b0;
        n_checks++; if (done !== 1'b1 || timeout !== 1'b0 || cycles !== 16'd19) begin n_fail++; $display("FAIL halt_wins: done %b timeout %b cycles %0d req 1/0/19", done, timeout, cycles); end
        n_checks++; if (mem[0] !== 8'h80 || mem[31] !== 8'h9F) begin n_fail++; $display("FAIL reload_mem: mem0 %h mem31 %h req 80/9F", mem[0], mem[31]); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        rst          = 1'b1;
        start        = 1'b0;
        cpu_halt     = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        test_reset();
        test_abort_load();
        test_back_to_back();
        test_start_ignored_in_run();
        test_halt_count();
        test_rerun_from_done();
        test_throttled_load();
        test_timeout();
        test_halt_at_limit();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
